// File: rtl/video_timing_gen.sv
// Raster timing generator: blanking, syncs, position and SOF for the video pipe.
// Define VIDEO_TIMING_GEN_PATTERN_EN to add an 8-bar colour pattern on vid_rgb_o.
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cen_i,
  input  logic        en_i,
  output logic [1:0]  vh_blank_o,
  output logic [2:0]  dvh_sync_o,
  output logic [11:0] hcnt_o,
  output logic [10:0] vcnt_o,
  output logic        sof_o,
  output logic        running_o
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  ,
  output logic [23:0] vid_rgb_o
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_ON  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_OFF = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_ON  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_OFF = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [2:0] SYNC_IDLE = {1'b0, ~VS_POL, ~HS_POL};

  if (H_TOTAL > 4096) begin : g_h_chk
    $error("H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > 2048) begin : g_v_chk
    $error("V_TOTAL exceeds 2048");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_p_chk
    $error("porch and sync widths must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_e;

  state_e      st_q, st_d;
  logic [11:0] h_q, h_d, h_inc;
  logic [10:0] v_q, v_d, v_inc;
  logic        h_wrap, last;
  logic        act_d, hb_d, vb_d, hs_d, vs_d;

  always_comb begin
    h_wrap = (h_q == H_LAST);
    last   = h_wrap && (v_q == V_LAST);
    h_inc  = h_wrap ? 12'd0 : h_q + 12'd1;
    v_inc  = v_q;
    if (h_wrap) begin
      v_inc = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
    end
  end

  // STOP differs from RUN only in that the frame end returns to IDLE.
  always_comb begin
    st_d = st_q;
    h_d  = h_q;
    v_d  = v_q;
    unique case (st_q)
      IDLE: begin
        h_d = 12'd0;
        v_d = 11'd0;
        if (en_i) st_d = RUN;
      end
      RUN, STOP: begin
        if (last && !en_i) begin
          st_d = IDLE;
          h_d  = 12'd0;
          v_d  = 11'd0;
        end else begin
          st_d = en_i ? RUN : STOP;
          h_d  = h_inc;
          v_d  = v_inc;
        end
      end
      default: begin
        st_d = IDLE;
        h_d  = 12'd0;
        v_d  = 11'd0;
      end
    endcase
  end

  always_comb begin
    act_d = (st_d != IDLE);
    hb_d  = (h_d >= H_ACT);
    vb_d  = (v_d >= V_ACT);
    hs_d  = (h_d >= HS_ON) && (h_d < HS_OFF);
    vs_d  = (v_d >= VS_ON) && (v_d < VS_OFF);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q       <= IDLE;
      h_q        <= 12'd0;
      v_q        <= 11'd0;
      vh_blank_o <= 2'b11;
      dvh_sync_o <= SYNC_IDLE;
      sof_o      <= 1'b0;
    end else if (cen_i) begin
      st_q  <= st_d;
      h_q   <= h_d;
      v_q   <= v_d;
      sof_o <= act_d && (h_d == 12'd0) && (v_d == 11'd0);
      if (act_d) begin
        vh_blank_o <= {vb_d, hb_d};
        dvh_sync_o <= {~hb_d & ~vb_d,
                       vs_d ? VS_POL : ~VS_POL,
                       hs_d ? HS_POL : ~HS_POL};
      end else begin
        vh_blank_o <= 2'b11;
        dvh_sync_o <= SYNC_IDLE;
      end
    end
  end

  assign hcnt_o    = h_q;
  assign vcnt_o    = v_q;
  assign running_o = (st_q != IDLE);

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  localparam int          BAR_W    = H_ACTIVE / 8;
  localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

  if (H_ACTIVE < 8) begin : g_bar_chk
    $error("H_ACTIVE must be >= 8 for the bar pattern");
  end

  logic [11:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]  bar_q, bar_d;
  logic [23:0] rgb_d;

  // Bar counter tracks h; it saturates on the last bar so that any
  // remainder pixels of a non-multiple-of-8 width stay black.
  always_comb begin
    bar_cnt_d = bar_cnt_q;
    bar_d     = bar_q;
    if (!act_d || h_d == 12'd0) begin
      bar_cnt_d = 12'd0;
      bar_d     = 3'd0;
    end else if (bar_cnt_q == BAR_LAST) begin
      bar_cnt_d = 12'd0;
      if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
    end else begin
      bar_cnt_d = bar_cnt_q + 12'd1;
    end
  end

  always_comb begin
    rgb_d = 24'h000000;
    if (act_d && !hb_d && !vb_d) begin
      unique case (bar_d)
        3'd0: rgb_d = 24'hFFFFFF;
        3'd1: rgb_d = 24'hFFFF00;
        3'd2: rgb_d = 24'h00FFFF;
        3'd3: rgb_d = 24'h00FF00;
        3'd4: rgb_d = 24'hFF00FF;
        3'd5: rgb_d = 24'hFF0000;
        3'd6: rgb_d = 24'h0000FF;
        3'd7: rgb_d = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bar_cnt_q <= 12'd0;
      bar_q     <= 3'd0;
      vid_rgb_o <= 24'h000000;
    end else if (cen_i) begin
      bar_cnt_q <= bar_cnt_d;
      bar_q     <= bar_d;
      vid_rgb_o <= rgb_d;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced raster.
// Reference model tracks position per cen cycle; monitor compares at negedge.
module tb_video_timing_gen;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int HBP = 3;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 1;
  localparam bit HP  = 1'b1;
  localparam bit VP  = 1'b0;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam logic [2:0] SYNC_IDLE = {1'b0, ~VP, ~HP};

  logic        clk    = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cen_i  = 1'b0;
  logic        en_i   = 1'b0;
  logic [1:0]  vh_blank_o;
  logic [2:0]  dvh_sync_o;
  logic [11:0] hcnt_o;
  logic [10:0] vcnt_o;
  logic        sof_o;
  logic        running_o;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  logic [23:0] vid_rgb_o;
`endif

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HP), .VS_POL(VP)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .cen_i     (cen_i),
    .en_i      (en_i),
    .vh_blank_o(vh_blank_o),
    .dvh_sync_o(dvh_sync_o),
    .hcnt_o    (hcnt_o),
    .vcnt_o    (vcnt_o),
    .sof_o     (sof_o),
    .running_o (running_o)
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    ,
    .vid_rgb_o (vid_rgb_o)
`endif
  );

  typedef struct {
    logic [1:0]  blank;
    logic [2:0]  sync;
    logic [11:0] h;
    logic [10:0] v;
    logic        sof;
    logic        run;
    logic [23:0] rgb;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   mh = 0;
  int   mv = 0;
  bit   mrun = 1'b0;
  int   ncyc = 0;
  int   sof_t[$];
  int   hs_cnt = 0;
  int   vs_cnt = 0;
  logic sof_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    bit hb, vb, hs, vs;
    int b;
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    hb = (mh >= HA);
    vb = (mv >= VA);
    hs = (mh >= HA + HFP) && (mh < HA + HFP + HSW);
    vs = (mv >= VA + VFP) && (mv < VA + VFP + VSW);
    e.h = 12'(mh);
    e.v = 11'(mv);
    e.rgb = 24'h0;
    if (!mrun) begin
      e.blank = 2'b11;
      e.sync  = SYNC_IDLE;
      e.sof   = 1'b0;
      e.run   = 1'b0;
    end else begin
      e.blank = {vb, hb};
      e.sync  = {!hb && !vb, vs ? VP : ~VP, hs ? HP : ~HP};
      e.sof   = (mh == 0) && (mv == 0);
      e.run   = 1'b1;
      if (!hb && !vb) begin
        b = mh / (HA / 8);
        if (b > 7) b = 7;
        e.rgb = bars[b];
      end
    end
    return e;
  endfunction

  task automatic model_step(input bit en);
    if (!mrun) begin
      if (en) begin
        mrun = 1'b1;
        mh = 0;
        mv = 0;
      end
    end else if (mh == HT - 1 && mv == VT - 1 && !en) begin
      mrun = 1'b0;
      mh = 0;
      mv = 0;
    end else begin
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
    end
  endtask

  task automatic cyc(input bit en, input bit cen);
    en_i  = en;
    cen_i = cen;
    @(posedge clk);
    if (rst_ni) begin
      if (cen) model_step(en);
      sb.push_back(model_out());
    end
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_blank"}, 32'(vh_blank_o), 32'(2'b11));
    chk({tag, "_sync"}, 32'(dvh_sync_o), 32'(SYNC_IDLE));
    chk({tag, "_h"}, 32'(hcnt_o), 0);
    chk({tag, "_v"}, 32'(vcnt_o), 0);
    chk({tag, "_sof"}, 32'(sof_o), 0);
    chk({tag, "_run"}, 32'(running_o), 0);
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    chk({tag, "_rgb"}, 32'(vid_rgb_o), 0);
`endif
  endtask

  task automatic period_chk(input string tag, input int per);
    chk({tag, "_sof_n"}, 32'(sof_t.size() >= 2), 1);
    if (sof_t.size() >= 2) chk({tag, "_sof_per"}, sof_t[1] - sof_t[0], per);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_ni) begin
      sb.delete();
    end else if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("vh_blank", 32'(vh_blank_o), 32'(e.blank));
      chk("dvh_sync", 32'(dvh_sync_o), 32'(e.sync));
      chk("hcnt", 32'(hcnt_o), 32'(e.h));
      chk("vcnt", 32'(vcnt_o), 32'(e.v));
      chk("sof", 32'(sof_o), 32'(e.sof));
      chk("running", 32'(running_o), 32'(e.run));
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
      chk("rgb", 32'(vid_rgb_o), 32'(e.rgb));
`endif
    end
    if (sof_o && !sof_prev) sof_t.push_back(ncyc);
    sof_prev = sof_o;
    if (running_o && vcnt_o == 0 && dvh_sync_o[0] == HP) hs_cnt++;
    if (running_o && dvh_sync_o[1] == VP) vs_cnt++;
    ncyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    idle_chk("rst");
    rst_ni = 1'b1;
    repeat (4) cyc(1'b0, 1'b1);
    repeat (3) cyc(1'b1, 1'b0);

    // one full frame: sync widths, then the next SOF
    hs_cnt = 0;
    vs_cnt = 0;
    sof_t.delete();
    ncyc = 0;
    repeat (HT * VT) cyc(1'b1, 1'b1);
    @(negedge clk);
    #1;
    chk("hs_width", hs_cnt, HSW);
    chk("vs_width", vs_cnt, VSW * HT);
    repeat (HT * VT + 10) cyc(1'b1, 1'b1);
    period_chk("run", HT * VT);

    // asynchronous reset mid-line
    for (int i = 0; i < 2 * HT * VT && !(mh == 10 && mv == 3); i++)
      cyc(1'b1, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    idle_chk("arst");
    mrun = 1'b0;
    mh = 0;
    mv = 0;
    repeat (2) cyc(1'b1, 1'b1);
    rst_ni = 1'b1;
    repeat (3) cyc(1'b0, 1'b1);

    // half-rate pixel enable
    sof_t.delete();
    ncyc = 0;
    repeat (2 * HT * VT + 20) begin
      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b0);
    end
    period_chk("cen", 2 * HT * VT);

    // en dropped mid-frame: frame completes then idles
    for (int i = 0; i < 2 * HT * VT && !(mh == 10 && mv == 3); i++)
      cyc(1'b1, 1'b1);
    repeat (HT * VT + 20) cyc(1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("stop_run", 32'(running_o), 0);
    chk("stop_blank", 32'(vh_blank_o), 32'(2'b11));

    // en dropped then raised before frame end: no gap
    sof_t.delete();
    ncyc = 0;
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 2 * HT * VT && !(mh == 5 && mv == 4); i++)
      cyc(1'b1, 1'b1);
    repeat (30) cyc(1'b0, 1'b1);
    repeat (HT * VT) cyc(1'b1, 1'b1);
    period_chk("resume", HT * VT);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
